// File: rtl/euclidean_distance_vec.sv
// Squared Euclidean distance over VEC_LEN streamed element pairs: sum((a_i-b_i)^2).
// Latency: last element accepted at edge t gives ovalid after edge t+3 (|a-b|, square, accumulate, load).
// Backpressure: iready drops from the last accept until iack takes the held result; ivalid is ignored meanwhile.
module euclidean_distance_vec #(
  parameter int DATA_W  = 32,
  parameter int VEC_LEN = 16,
  parameter int SIGNED  = 0,
  localparam int CNT_W  = $clog2(VEC_LEN + 1),
  localparam int ACC_W  = 2 * DATA_W + 1 + $clog2(VEC_LEN)
) (
  input  logic              iclk,
  input  logic              irstn,
  input  logic [DATA_W-1:0] idata_0,
  input  logic [DATA_W-1:0] idata_1,
  input  logic              ivalid,
  output logic              iready,
  input  logic              iclear,
  input  logic              iack,
  output logic              ovalid,
  output logic [ACC_W-1:0]  odata,
  output logic              obusy
);

  localparam int SQ_W = 2 * DATA_W + 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;

  logic               s1_vld;
  logic [DATA_W:0]    s1_d;
  logic               s2_vld;
  logic [SQ_W-1:0]    s2_sq;

  logic               accept;
  logic               clr_pipe;
  logic               hold_done;
  logic               sign_a;
  logic               sign_b;
  logic [DATA_W:0]    ext_a;
  logic [DATA_W:0]    ext_b;
  logic [DATA_W:0]    diff;
  logic [DATA_W:0]    abs_d;
  logic [SQ_W-1:0]    d_ext;

  // An abort in the same cycle as an accept throws the element away.
  assign accept    = ivalid && iready && !iclear;
  // The finished result in HOLD is never destroyed by an abort.
  assign clr_pipe  = iclear && (state != S_HOLD);
  assign hold_done = (state == S_HOLD) && iack;
  assign obusy     = (state != S_IDLE);

  // The difference of two DATA_W operands always fits DATA_W+1 signed bits, so its magnitude does too.
  assign sign_a = (SIGNED != 0) && idata_0[DATA_W-1];
  assign sign_b = (SIGNED != 0) && idata_1[DATA_W-1];
  assign ext_a  = {sign_a, idata_0};
  assign ext_b  = {sign_b, idata_1};
  assign diff   = ext_a - ext_b;
  assign abs_d  = diff[DATA_W] ? -diff : diff;
  assign d_ext  = {{(SQ_W - DATA_W - 1){1'b0}}, s1_d};

  // Element pipeline: stage 1 holds |a-b|, stage 2 holds its square.
  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      s1_vld <= 1'b0;
      s1_d   <= '0;
      s2_vld <= 1'b0;
      s2_sq  <= '0;
    end else begin
      if (clr_pipe) begin
        s1_vld <= 1'b0;
        s2_vld <= 1'b0;
      end else begin
        s1_vld <= accept;
        s2_vld <= s1_vld;
      end
      if (accept) s1_d  <= abs_d;
      if (s1_vld) s2_sq <= d_ext * d_ext;
    end
  end

  // Accumulator: sums squares, cleared by an abort or when the result is handed off.
  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      acc <= '0;
    end else if (clr_pipe || hold_done) begin
      acc <= '0;
    end else if (s2_vld) begin
      acc <= acc + {{(ACC_W - SQ_W){1'b0}}, s2_sq};
    end
  end

  // Control FSM with registered iready/ovalid/odata; iready follows the next state.
  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      iready <= 1'b0;
      ovalid <= 1'b0;
      odata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          iready <= 1'b1;
          if (iclear) begin
            cnt <= '0;
          end else if (accept) begin
            cnt   <= CNT_W'(1);
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (iclear) begin
            state  <= S_IDLE;
            cnt    <= '0;
            iready <= 1'b1;
          end else if (accept) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              state  <= S_DRAIN;
              iready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (iclear) begin
            state  <= S_IDLE;
            cnt    <= '0;
            iready <= 1'b1;
          end else if (!s1_vld && !s2_vld) begin
            odata  <= acc;
            ovalid <= 1'b1;
            state  <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (iack) begin
            state  <= S_IDLE;
            cnt    <= '0;
            ovalid <= 1'b0;
            iready <= 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          cnt    <= '0;
          iready <= 1'b1;
          ovalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_euclidean_distance_vec.sv
// Bench for euclidean_distance_vec: unsigned VEC_LEN=4 and signed VEC_LEN=2 instances.
// Expected sums are queued when a vector is issued; monitors pop them when ovalid rises.
// Directed checks cover reset values, latency, hold under backpressure, abort and async reset.
module tb_euclidean_distance_vec;

  localparam int W   = 32;
  localparam int AW0 = 2 * W + 1 + $clog2(4);
  localparam int AW1 = 2 * W + 1 + $clog2(2);

  logic           iclk = 1'b0;
  logic           irstn;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           vld0, vld1, clr0, clr1, ack0, ack1;
  logic           rdy0, rdy1, ov0, ov1, busy0, busy1;
  logic [AW0-1:0] odata0;
  logic [AW1-1:0] odata1;

  int n_chk  = 0;
  int n_pass = 0;
  logic [68:0] exp0[$];
  logic [68:0] exp1[$];
  logic ov0_q = 1'b0;
  logic ov1_q = 1'b0;

  localparam logic [68:0] EXP_T1 = 69'h0_FFFF_FFFE_0000_0063;
  localparam logic [68:0] EXP_S  = 69'h0_FFFF_FFFE_0000_0091;

  always #5 iclk = ~iclk;

  euclidean_distance_vec #(.DATA_W(W), .VEC_LEN(4), .SIGNED(0)) u_dut0 (
    .iclk(iclk), .irstn(irstn), .idata_0(a0), .idata_1(b0), .ivalid(vld0),
    .iready(rdy0), .iclear(clr0), .iack(ack0), .ovalid(ov0), .odata(odata0), .obusy(busy0)
  );

  euclidean_distance_vec #(.DATA_W(W), .VEC_LEN(2), .SIGNED(1)) u_dut1 (
    .iclk(iclk), .irstn(irstn), .idata_0(a1), .idata_1(b1), .ivalid(vld1),
    .iready(rdy1), .iclear(clr1), .iack(ack1), .ovalid(ov1), .odata(odata1), .obusy(busy1)
  );

  task automatic chk_w(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // Scoreboard monitors: each new result is compared against the oldest queued expectation.
  always @(negedge iclk) begin
    if (ov0 && !ov0_q) begin
      if (exp0.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_result0: got %h, expected no result", odata0);
      end else begin
        chk_w("result0", 69'(odata0), exp0.pop_front());
      end
    end
    ov0_q <= ov0;
  end

  always @(negedge iclk) begin
    if (ov1 && !ov1_q) begin
      if (exp1.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_result1: got %h, expected no result", odata1);
      end else begin
        chk_w("result1", 69'(odata1), exp1.pop_front());
      end
    end
    ov1_q <= ov1;
  end

  // Present one element and hold it until an edge with iready high takes it.
  task automatic send(input int u, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    if (u == 0) begin a0 = a; b0 = b; vld0 = 1'b1; end
    else        begin a1 = a; b1 = b; vld1 = 1'b1; end
    @(negedge iclk);
    while ((((u == 0) ? rdy0 : rdy1) == 1'b0) && (n < 50)) begin
      @(negedge iclk);
      n++;
    end
    if (((u == 0) ? rdy0 : rdy1) == 1'b0) begin
      n_chk++;
      $display("FAIL send_timeout%0d: iready got 0, expected 1", u);
    end
    @(posedge iclk);
    #1;
    if (u == 0) vld0 = 1'b0;
    else        vld1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  task automatic wait_idle(input int u);
    int n;
    n = 0;
    @(negedge iclk);
    while ((((u == 0) ? busy0 : busy1) == 1'b1) && (n < 100)) begin
      @(negedge iclk);
      n++;
    end
    if (((u == 0) ? busy0 : busy1) == 1'b1) begin
      n_chk++;
      $display("FAIL idle_timeout%0d: obusy got 1, expected 0", u);
    end
    @(posedge iclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got no end, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    irstn = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    vld0 = 1'b0; vld1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    ack0 = 1'b0; ack1 = 1'b1;

    // Reset values
    #2;
    chk_b("rst_iready0", rdy0, 1'b0);
    chk_b("rst_ovalid0", ov0, 1'b0);
    chk_b("rst_obusy0", busy0, 1'b0);
    chk_w("rst_odata0", 69'(odata0), 69'd0);
    chk_b("rst_iready1", rdy1, 1'b0);
    #10 irstn = 1'b1;
    @(negedge iclk);
    chk_b("post_rst_iready0", rdy0, 1'b1);
    @(posedge iclk);
    #1;

    // Signed pairs: (-5,7) and (min,max)
    exp1.push_back(EXP_S);
    send(1, 32'hFFFF_FFFB, 32'd7);
    send(1, 32'h8000_0000, 32'h7FFF_FFFF);
    wait_idle(1);

    // Unsigned back-to-back with latency and backpressure
    exp0.push_back(EXP_T1);
    send(0, 32'd10, 32'd3);
    send(0, 32'd3, 32'd10);
    send(0, 32'd0, 32'd0);
    send(0, 32'hFFFF_FFFF, 32'd0);
    @(negedge iclk);
    chk_b("drain_iready", rdy0, 1'b0);
    chk_b("drain_obusy", busy0, 1'b1);
    chk_b("lat_c1", ov0, 1'b0);
    @(negedge iclk);
    chk_b("lat_c2", ov0, 1'b0);
    @(negedge iclk);
    chk_b("lat_c3", ov0, 1'b0);
    @(negedge iclk);
    chk_b("lat_c4", ov0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge iclk);
      #1;
      vld0 = i[0];
      a0 = 32'(i + 100);
      b0 = 32'd1;
      @(negedge iclk);
      chk_b("hold_ovalid", ov0, 1'b1);
      chk_b("hold_iready", rdy0, 1'b0);
      chk_w("hold_odata", 69'(odata0), EXP_T1);
    end
    @(posedge iclk);
    #1;
    vld0 = 1'b0;
    ack0 = 1'b1;
    @(negedge iclk);
    chk_b("ack_pending_ovalid", ov0, 1'b1);
    @(negedge iclk);
    chk_b("ack_ovalid", ov0, 1'b0);
    chk_w("ack_odata_kept", 69'(odata0), EXP_T1);
    chk_b("ack_iready", rdy0, 1'b1);
    @(posedge iclk);
    #1;

    // Gapped input
    exp0.push_back(69'd4);
    send(0, 32'd1, 32'd0);
    send(0, 32'd1, 32'd0);
    idle(1);
    send(0, 32'd1, 32'd0);
    idle(3);
    send(0, 32'd1, 32'd0);
    wait_idle(0);

    // Abort after two elements, with a discarded accept in the same cycle
    send(0, 32'd5, 32'd0);
    send(0, 32'd5, 32'd0);
    a0 = 32'd7;
    b0 = 32'd0;
    vld0 = 1'b1;
    clr0 = 1'b1;
    @(posedge iclk);
    #1;
    clr0 = 1'b0;
    vld0 = 1'b0;
    @(negedge iclk);
    chk_b("abort_obusy", busy0, 1'b0);
    @(posedge iclk);
    #1;
    exp0.push_back(69'd16);
    for (int i = 0; i < 4; i++) send(0, 32'd2, 32'd0);
    wait_idle(0);

    // Asynchronous reset mid-vector
    send(0, 32'd3, 32'd0);
    send(0, 32'd3, 32'd0);
    #1 irstn = 1'b0;
    #1;
    chk_b("arst_ovalid", ov0, 1'b0);
    chk_w("arst_odata", 69'(odata0), 69'd0);
    chk_b("arst_obusy", busy0, 1'b0);
    chk_b("arst_iready", rdy0, 1'b0);
    #1 irstn = 1'b1;
    @(posedge iclk);
    #1;
    exp0.push_back(69'd74);
    send(0, 32'd0, 32'd6);
    send(0, 32'd6, 32'd0);
    send(0, 32'd1, 32'd2);
    send(0, 32'd2, 32'd1);
    wait_idle(0);

    repeat (5) @(posedge iclk);
    chk_w("queue0_drained", 69'(exp0.size()), 69'd0);
    chk_w("queue1_drained", 69'(exp1.size()), 69'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
